serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes a - b one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow, and sits directly upstream of the full subtractor cell, feeding it x, y and bin each cycle.
- Operands load on a start pulse.
- Result and final borrow are presented with a one-cycle done pulse.
- Serves as the area-minimal arithmetic stage for multi-bit subtraction in the datapath.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  one-cycle pulse; diff/borrow_out valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
borrow_out  output  1  final borrow; 1 iff a < b (unsigned); held with diff

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0.
  - Shift registers, borrow flop and bit counter are cleared.
  - Reset mid-operation aborts the subtraction; no done is produced.
- States: IDLE, SHIFT, DONE (2-bit encoded).
- IDLE:
  - On an edge with start=1, load a into the x shift register and b into the y shift register.
  - Clear the borrow flop and the counter, then go to SHIFT.
  - diff and borrow_out keep their previous values until the result update in SHIFT.
- SHIFT (busy=1), each edge:
  - x = xsr[0], y = ysr[0], bin = borrow flop.
  - d = x ^ y ^ bin.
  - br = (~x & y) | (~x & bin) | (y & bin).
  - Shift xsr and ysr right by 1.
  - Shift d into the MSB of the result register (result shifts right).
  - Borrow flop <= br; counter increments.
  - On the edge processing bit WIDTH-1: go to DONE, diff <= final result register, borrow_out <= br.
- DONE: done=1 for exactly one cycle, busy=0. The next edge returns to IDLE.
- Latency: start accepted at edge 0; bits processed on edges 1..WIDTH; done high in the cycle after edge WIDTH.
- Throughput: one operation per WIDTH+2 cycles.
- start is ignored in SHIFT and DONE; no queuing and no error flag.
- Operands are captured at acceptance; a/b changes while busy have no effect.
- start held high continuously: a new operation is accepted on every return to IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around: diff = a - b + 2^WIDTH when a < b, with borrow_out=1.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, a=100, b=37, start pulse -> after 9 cycles done=1 for 1 cycle, diff=63 (0x3F), borrow_out=0; busy high exactly 8 cycles.
2. a=5, b=9 -> diff=0xFC, borrow_out=1; a=0, b=1 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
3. Start re-pulsed during SHIFT with a=1, b=1, first operation a=200, b=55 -> exactly one done, diff=145 (0x91), borrow_out=0; second start ignored.
4. rst asserted asynchronously mid-SHIFT (after 3 bit edges) -> busy, done, diff, borrow_out = 0 immediately. After release, the state is IDLE and no done ever appears for the aborted operation.
5. WIDTH=4, exhaustive a, b in 0..15 -> diff == (a - b) & 0xF and borrow_out == (a < b) for all 256 pairs, each checked on the done cycle.
6. start held high for three back-to-back operations -> done pulses spaced WIDTH+2 cycles apart. diff holds its value between done pulses and updates only when each new operation completes.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, registered borrow,
// LSB first, one result bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xsr_q, xsr_d;
  logic [WIDTH-1:0] ysr_q, ysr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic x, y, bin, d, br;

  // Full-subtractor cell
  assign x   = xsr_q[0];
  assign y   = ysr_q[0];
  assign bin = bor_q;
  assign d   = x ^ y ^ bin;
  assign br  = (~x & y) | (~x & bin) | (y & bin);

  always_comb begin
    state_d = state_q;
    xsr_d   = xsr_q;
    ysr_d   = ysr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          xsr_d   = a;
          ysr_d   = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        xsr_d = xsr_q >> 1;
        ysr_d = ysr_q >> 1;
        res_d = {d, res_q[WIDTH-1:1]};
        bor_d = br;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = {d, res_q[WIDTH-1:1]};
          bout_d  = br;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xsr_q   <= '0;
      ysr_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      xsr_q   <= xsr_d;
      ysr_q   <= ysr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
